// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared states, instruction bit positions and idle word for core_ctrl
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_KLOAD, S_XLOAD, S_EXEC, S_DRAIN, S_ACC, S_DONE
  } state_t;

  localparam int INST_W   = 34;
  localparam int ACC      = 33;
  localparam int PCEN     = 32;
  localparam int PWEN     = 31;
  localparam int PADDR_HI = 30;
  localparam int PADDR_LO = 20;
  localparam int XCEN     = 19;
  localparam int XWEN     = 18;
  localparam int XADDR_HI = 17;
  localparam int XADDR_LO = 7;
  localparam int OFIFO_RD = 6;
  localparam int L0_RD    = 3;
  localparam int L0_WR    = 2;
  localparam int EXEC     = 1;
  localparam int LOAD     = 0;

  // Both memories disabled and read-only; every control strobe low.
  localparam logic [INST_W-1:0] IDLE_INST =
    (34'd1 << PCEN) | (34'd1 << PWEN) | (34'd1 << XCEN) | (34'd1 << XWEN);

endpackage

// File: rtl/core_ctrl_if.sv
// rtl/core_ctrl_if.sv - host-facing bundle of core_ctrl: layer launch, ofifo status, instruction word
import core_ctrl_pkg::*;

interface core_ctrl_if;
  logic              start;
  logic [10:0]       w_base;
  logic [10:0]       x_base;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;

  modport master (output start, w_base, x_base, ofifo_valid, input inst, busy, done);
  modport slave  (input start, w_base, x_base, ofifo_valid, output inst, busy, done);
endinterface

// File: rtl/core_ctrl_cnt.sv
// rtl/core_ctrl_cnt.sv - loadable up-counter with terminal-count flag
module ctrl_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] q,
  output logic         tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
    else if (inc)  q <= q + W'(1);
  end

  assign tc = (q == last);

endmodule

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - layer sequencer: weight/activation loads, execute, psum drain, final accumulation
import core_ctrl_pkg::*;

module core_ctrl #(
  parameter int COL      = 8,
  parameter int LEN_KIJ  = 9,
  parameter int LEN_NIJ  = 36,
  parameter int LEN_ONIJ = 16
) (
  input  logic        clk,
  input  logic        reset,
  core_ctrl_if.slave  bus
);

  localparam int CW = 16;
  localparam logic [CW-1:0] COL_C  = CW'(COL);
  localparam logic [CW-1:0] NIJ_C  = CW'(LEN_NIJ);
  localparam logic [CW-1:0] KIJ_C  = CW'(LEN_KIJ);
  localparam logic [CW-1:0] ONIJ_C = CW'(LEN_ONIJ);

  state_t            st, st_nx;
  logic [10:0]       w_base_q, x_base_q;
  logic              pend, pend_nx;
  logic [INST_W-1:0] inst_q, inst_nx;
  logic              busy_q, busy_nx, done_q, done_nx;
  logic              accept;

  logic [CW-1:0] step, kij, o, step_last;
  logic          step_tc, kij_tc, o_tc;
  logic          step_clr, step_inc, kij_clr, kij_inc, o_clr, o_inc;
  logic [CW-1:0] ld_n;
  logic [10:0]   ld_base;

  ctrl_cnt #(.W(CW)) u_step (
    .clk(clk), .reset(reset), .load(step_clr), .d('0), .inc(step_inc),
    .last(step_last), .q(step), .tc(step_tc)
  );
  ctrl_cnt #(.W(CW)) u_kij (
    .clk(clk), .reset(reset), .load(kij_clr), .d('0), .inc(kij_inc),
    .last(KIJ_C - CW'(1)), .q(kij), .tc(kij_tc)
  );
  ctrl_cnt #(.W(CW)) u_o (
    .clk(clk), .reset(reset), .load(o_clr), .d('0), .inc(o_inc),
    .last(ONIJ_C - CW'(1)), .q(o), .tc(o_tc)
  );

  // The done pulse is visible while the FSM already sits in IDLE, so it also masks start.
  assign accept  = (st == S_IDLE) && bus.start && !done_q;
  assign ld_n    = (st == S_WLOAD) ? COL_C : NIJ_C;
  assign ld_base = (st == S_WLOAD) ? (w_base_q + 11'(kij * COL_C)) : x_base_q;

  always_comb begin
    st_nx     = st;
    pend_nx   = 1'b0;
    inst_nx   = IDLE_INST;
    done_nx   = 1'b0;
    step_clr  = 1'b0;
    step_inc  = 1'b0;
    step_last = '0;
    kij_clr   = 1'b0;
    kij_inc   = 1'b0;
    o_clr     = 1'b0;
    o_inc     = 1'b0;
    case (st)
      S_IDLE: begin
        if (accept) begin
          st_nx    = S_WLOAD;
          step_clr = 1'b1;
          kij_clr  = 1'b1;
          o_clr    = 1'b1;
        end
      end
      // pend marks a read issued last cycle whose data reaches L0 now.
      S_WLOAD, S_XLOAD: begin
        if (step < ld_n) begin
          inst_nx[XCEN]                = 1'b0;
          inst_nx[XADDR_HI:XADDR_LO]   = ld_base + 11'(step);
          step_inc                     = 1'b1;
          pend_nx                      = 1'b1;
        end
        if (pend) inst_nx[L0_WR] = 1'b1;
        if (pend && step == ld_n) begin
          st_nx    = (st == S_WLOAD) ? S_KLOAD : S_EXEC;
          step_clr = 1'b1;
        end
      end
      S_KLOAD, S_EXEC: begin
        step_last      = ((st == S_KLOAD) ? COL_C : NIJ_C) - CW'(1);
        inst_nx[L0_RD] = 1'b1;
        inst_nx[LOAD]  = (st == S_KLOAD);
        inst_nx[EXEC]  = (st == S_EXEC);
        step_inc       = 1'b1;
        if (step_tc) begin
          st_nx    = (st == S_KLOAD) ? S_XLOAD : S_DRAIN;
          step_clr = 1'b1;
        end
      end
      S_DRAIN: begin
        if (pend) begin
          inst_nx[PCEN]              = 1'b0;
          inst_nx[PWEN]              = 1'b0;
          inst_nx[PADDR_HI:PADDR_LO] = 11'(kij * NIJ_C) + 11'(step - CW'(1));
        end
        if (bus.ofifo_valid && step < NIJ_C) begin
          inst_nx[OFIFO_RD] = 1'b1;
          step_inc          = 1'b1;
          pend_nx           = 1'b1;
        end
        if (pend && step == NIJ_C) begin
          step_clr = 1'b1;
          kij_inc  = 1'b1;
          st_nx    = kij_tc ? S_ACC : S_WLOAD;
        end
      end
      // step walks k fastest, o slowest; pend flags the trailing latency cycle.
      S_ACC: begin
        inst_nx[ACC] = 1'b1;
        if (pend) begin
          st_nx = S_DONE;
        end else begin
          step_last                  = KIJ_C - CW'(1);
          inst_nx[PCEN]              = 1'b0;
          inst_nx[PADDR_HI:PADDR_LO] = 11'(step * NIJ_C) + 11'(o);
          step_inc                   = 1'b1;
          if (step_tc) begin
            step_clr = 1'b1;
            o_inc    = 1'b1;
            pend_nx  = o_tc;
          end
        end
      end
      S_DONE: begin
        done_nx = 1'b1;
        st_nx   = S_IDLE;
      end
      default: st_nx = S_IDLE;
    endcase
    busy_nx = accept || (st != S_IDLE && st != S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= S_IDLE;
      pend     <= 1'b0;
      w_base_q <= '0;
      x_base_q <= '0;
      inst_q   <= IDLE_INST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      st     <= st_nx;
      pend   <= pend_nx;
      inst_q <= inst_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
      if (accept) begin
        w_base_q <= bus.w_base;
        x_base_q <= bus.x_base;
      end
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - self-checking bench for core_ctrl
`timescale 1ns/1ps
module tb_core_ctrl;
  import core_ctrl_pkg::*;

  localparam int COL = 8, KIJ = 9, NIJ = 36, ONIJ = 16;
  localparam logic [33:0] IDLE_LIT = 34'h1800C0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  core_ctrl_if bus();

  core_ctrl #(.COL(COL), .LEN_KIJ(KIJ), .LEN_NIJ(NIJ), .LEN_ONIJ(ONIJ)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  logic [10:0] xq[$], pq[$], aq[$], xlog[$], alog[$];
  int cnt_load, cnt_exec, cnt_ofrd, cnt_pwr, cnt_prd, cnt_tail, cnt_done, cnt_l0wr;
  logic prev_xrd = 0, prev_ofrd = 0, prev_valid = 0, prev_tail = 0, busy_exp = 0;
  int vmode = 1;
  logic [33:0] mi;
  logic m_xrd, m_pwr, m_prd, m_tail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic build_layer(input logic [10:0] w, input logic [10:0] x);
    xq.delete(); pq.delete(); aq.delete(); xlog.delete(); alog.delete();
    cnt_load = 0; cnt_exec = 0; cnt_ofrd = 0; cnt_pwr = 0;
    cnt_prd = 0; cnt_tail = 0; cnt_done = 0; cnt_l0wr = 0;
    for (int k = 0; k < KIJ; k++) begin
      for (int i = 0; i < COL; i++) xq.push_back(11'(w + k * COL + i));
      for (int n = 0; n < NIJ; n++) xq.push_back(11'(x + n));
      for (int m = 0; m < NIJ; m++) pq.push_back(11'(k * NIJ + m));
    end
    for (int o = 0; o < ONIJ; o++)
      for (int k = 0; k < KIJ; k++) aq.push_back(11'(k * NIJ + o));
  endtask

  task automatic do_start(input logic [10:0] w, input logic [10:0] x);
    @(posedge clk); #2;
    build_layer(w, x);
    bus.w_base = w; bus.x_base = x; bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    busy_exp  = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (cnt_done < 1 && c < budget) begin @(posedge clk); c++; end
    check("done_timeout", 64'(cnt_done >= 1), 1);
  endtask

  task automatic end_layer_checks();
    check("xq_empty", xq.size(), 0);
    check("pq_empty", pq.size(), 0);
    check("aq_empty", aq.size(), 0);
    check("load_cycles", cnt_load, 72);
    check("exec_cycles", cnt_exec, 324);
    check("l0_wr_cycles", cnt_l0wr, 396);
    check("ofifo_rds", cnt_ofrd, 324);
    check("pmem_writes", cnt_pwr, 324);
    check("acc_reads", cnt_prd, 144);
    check("acc_tail", cnt_tail, 1);
    check("done_pulses", cnt_done, 1);
  endtask

  always @(posedge clk) begin
    #2;
    case (vmode)
      0:       bus.ofifo_valid = 1'b0;
      1:       bus.ofifo_valid = 1'b1;
      default: bus.ofifo_valid = 1'($urandom_range(0, 1));
    endcase
  end

  // Event-level checker: every issued address is popped from the per-layer expectation queues.
  always @(negedge clk) begin
    if (reset) begin
      prev_xrd = 0; prev_ofrd = 0; prev_valid = 0; prev_tail = 0;
    end else begin
      mi     = bus.inst;
      m_xrd  = !mi[XCEN];
      m_pwr  = !mi[PCEN] && !mi[PWEN];
      m_prd  = !mi[PCEN] && mi[PWEN];
      m_tail = mi[ACC] && mi[PCEN];
      check("xmem_wen", mi[XWEN], 1);
      check("reserved", mi[5:4], 0);
      if (m_xrd) begin
        xlog.push_back(mi[XADDR_HI:XADDR_LO]);
        if (xq.size() == 0) check("xrd_unexpected", 1, 0);
        else check("xmem_addr", mi[XADDR_HI:XADDR_LO], xq.pop_front());
      end
      check("l0_wr_delay", mi[L0_WR], prev_xrd);
      if (mi[L0_WR]) cnt_l0wr++;
      check("pwr_delay", m_pwr, prev_ofrd);
      if (mi[OFIFO_RD]) begin
        cnt_ofrd++;
        check("ofrd_valid", prev_valid, 1);
      end
      if (m_pwr) begin
        cnt_pwr++;
        check("pwr_acc", mi[ACC], 0);
        if (pq.size() == 0) check("pwr_unexpected", 1, 0);
        else check("pmem_waddr", mi[PADDR_HI:PADDR_LO], pq.pop_front());
      end
      if (m_prd) begin
        cnt_prd++;
        alog.push_back(mi[PADDR_HI:PADDR_LO]);
        check("prd_acc", mi[ACC], 1);
        if (aq.size() == 0) check("prd_unexpected", 1, 0);
        else check("pmem_raddr", mi[PADDR_HI:PADDR_LO], aq.pop_front());
      end
      if (m_tail) begin
        cnt_tail++;
        check("tail_after_reads", aq.size(), 0);
      end
      if (mi[LOAD]) begin cnt_load++; check("load_l0rd", mi[L0_RD], 1); end
      if (mi[EXEC]) begin cnt_exec++; check("exec_l0rd", mi[L0_RD], 1); end
      if (bus.done) begin
        cnt_done++;
        busy_exp = 1'b0;
        check("done_inst", mi, IDLE_LIT);
        check("done_after_tail", prev_tail, 1);
      end
      check("busy", bus.busy, busy_exp);
      prev_xrd   = m_xrd;
      prev_ofrd  = mi[OFIFO_RD];
      prev_valid = bus.ofifo_valid;
      prev_tail  = m_tail;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    bus.start = 1'b0; bus.w_base = '0; bus.x_base = '0; bus.ofifo_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst", bus.inst, IDLE_LIT);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    @(posedge clk); #2 reset = 1'b0;

    // Full layer, first DRAIN starved of ofifo_valid for 20 cycles.
    vmode = 0;
    do_start(11'h100, 11'h200);
    c = 0;
    while (cnt_exec < NIJ && c < 500) begin @(posedge clk); c++; end
    check("reach_drain0", 64'(cnt_exec >= NIJ), 1);
    repeat (20) @(posedge clk);
    check("stall_ofrd", cnt_ofrd, 0);
    check("stall_pwr", cnt_pwr, 0);
    check("stall_xq_left", xq.size(), 352);
    vmode = 1;
    wait_done(4000);
    repeat (3) @(posedge clk);
    end_layer_checks();
    check("w_first", xlog[0], 11'h100);
    check("w_last", xlog[7], 11'h107);
    check("x_first", xlog[8], 11'h200);
    check("acc_a0", alog[0], 0);
    check("acc_a1", alog[1], 36);
    check("acc_a2", alog[2], 72);
    check("acc_alast", alog[143], 303);

    // Abandon a layer with reset during EXEC of kij=3.
    vmode = 2;
    do_start(11'h040, 11'h300);
    c = 0;
    while (cnt_exec < 3 * NIJ + 5 && c < 3000) begin @(posedge clk); c++; end
    check("reach_exec3", 64'(cnt_exec >= 3 * NIJ + 5), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_inst", bus.inst, IDLE_LIT);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_done", bus.done, 0);
    busy_exp = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Restart with wrapping bases; start pulses during XLOAD and on the done cycle.
    do_start(11'h7FC, 11'h7F0);
    c = 0;
    while (xlog.size() < COL + 2 && c < 200) begin @(posedge clk); c++; end
    check("reach_xload", 64'(xlog.size() >= COL + 2), 1);
    #2 bus.start = 1'b1; bus.w_base = 11'h555; bus.x_base = 11'h555;
    @(posedge clk); #2 bus.start = 1'b0;
    c = 0;
    while (bus.done !== 1'b1 && c < 4000) begin @(negedge clk); c++; end
    check("done_seen", bus.done, 1);
    bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    end_layer_checks();
    check("wrap_w0", xlog[0], 11'h7FC);
    check("wrap_w3", xlog[3], 11'h7FF);
    check("wrap_w4", xlog[4], 11'h000);
    check("wrap_w7", xlog[7], 11'h003);
    check("wrap_x16", xlog[24], 11'h000);
    check("post_done_inst", bus.inst, IDLE_LIT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- COL, 8, PE columns; weight words per kernel load.
- LEN_KIJ, 9, kernel positions per layer.
- LEN_NIJ, 36, input pixels per kij pass.
- LEN_ONIJ, 16, output pixels accumulated in the final phase.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the only clock.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, one-cycle pulse that begins a layer; ignored while busy.
- w_base, in, 11, xmem address of the kij=0 weights; sampled on start.
- x_base, in, 11, xmem address of activations; sampled on start.
- ofifo_valid, in, 1, core output FIFO holds a psum row.
- inst, out, 34, core instruction word; fields per REQ-003.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse on layer completion.
REQ-003 inst fields:
- [33] accumulate.
- [32] pmem CEN (active-low).
- [31] pmem WEN (active-low).
- [30:20] pmem address.
- [19] xmem CEN (active-low).
- [18] xmem WEN (active-low; always 1 here).
- [17:7] xmem address.
- [6] ofifo_rd.
- [5:4] reserved 0.
- [3] l0_rd.
- [2] l0_wr.
- [1] execute.
- [0] load_kernel.

Function
REQ-004 FSM states: IDLE, WLOAD, KLOAD, XLOAD, EXEC, DRAIN, ACC, DONE.
REQ-005 In IDLE, inst is the idle word: CEN bits 1, WEN bits 1, every other bit 0.
REQ-006 start in IDLE latches both bases, clears kij, and enters WLOAD.
REQ-007 WLOAD issues COL xmem reads at w_base + kij*COL + i, for i = 0..COL-1.
REQ-008 l0_wr is asserted exactly one cycle after each xmem read, covering the SRAM's one-cycle latency; the state exits after the last delayed l0_wr.
REQ-009 KLOAD asserts l0_rd with load_kernel for COL cycles.
REQ-010 XLOAD issues LEN_NIJ reads at x_base + n, with the same one-cycle-delayed l0_wr.
REQ-011 EXEC asserts l0_rd with execute for LEN_NIJ cycles.
REQ-012 DRAIN asserts ofifo_rd only in cycles where ofifo_valid=1.
REQ-013 Each ofifo_rd produces a pmem write one cycle later: CEN=0, WEN=0, address kij*LEN_NIJ + m, where m counts writes.
REQ-014 DRAIN exits after LEN_NIJ writes.
REQ-015 If ofifo_valid is low, DRAIN waits indefinitely with no timeout.
REQ-016 After DRAIN, kij increments. kij < LEN_KIJ returns to WLOAD; otherwise the FSM enters ACC.
REQ-017 ACC, for o = 0..LEN_ONIJ-1 and k = 0..LEN_KIJ-1, issues a pmem read at k*LEN_NIJ + o with accumulate=1 and WEN=1.
REQ-018 ACC takes LEN_ONIJ*LEN_KIJ cycles, plus one trailing cycle with accumulate=1 and CEN=1 to absorb read latency.
REQ-019 DONE lasts one cycle: done=1, idle inst, then IDLE.
REQ-020 xmem and pmem are never both written in one cycle; xmem is never written.
REQ-021 Address arithmetic is 11-bit unsigned and wraps modulo 2048 without error.
REQ-022 start while busy has no effect. start in the DONE cycle is ignored.
REQ-023 inst, busy and done are registered outputs; no combinational path from any input to any output.

Reset
REQ-024 reset asynchronously forces IDLE, clears all counters and base registers, drives the idle inst word, busy=0 and done=0.
REQ-025 reset mid-operation abandons the layer. No pmem write or read issues after reset asserts. The first post-reset cycle is IDLE.

Structure
REQ-026 The shared package holds:
- the FSM state enum;
- inst bit-position constants (ACC, PCEN, PWEN, PADDR_HI/LO, XCEN, XWEN, XADDR_HI/LO, OFIFO_RD, L0_RD, L0_WR, EXEC, LOAD);
- the idle-word constant.
REQ-027 One sub-module, ctrl_cnt: a loadable up-counter with terminal-count flag, instantiated for the step index, kij and o.

Verification
REQ-028 Scenario 1: w_base=0x100, start, kij=0 -> xmem reads at 0x100..0x107; l0_wr asserted on cycles +1..+8.
REQ-029 Scenario 2: ofifo_valid held 0 for 20 cycles in DRAIN -> no ofifo_rd and no pmem write. Then ofifo_valid=1 -> LEN_NIJ writes at kij*36 + 0..35.
REQ-030 Scenario 3: full layer with defaults -> 9 WLOAD/KLOAD/XLOAD/EXEC/DRAIN iterations, then 144 ACC reads with accumulate=1; the first ACC addresses are 0, 36, 72; done pulses once; busy falls with done.
REQ-031 Scenario 4: reset asserted during EXEC of kij=3 -> inst equals the idle word in the same cycle (asynchronous); busy=0; a following start restarts at kij=0.
REQ-032 Scenario 5: w_base=0x7FC, kij=0 -> addresses 0x7FC..0x7FF, then 0x000..0x003.
REQ-033 Scenario 6: start pulsed during XLOAD and again on the DONE cycle -> both ignored; FSM sequence unchanged; exactly one done pulse.
